// File: rtl/sram_blwl_bank.sv
// Bit-line / word-line programmed configuration bank: one row per request,
// written through SETUP/PULSE/HOLD phases (erase-then-set for RRAM) or read back.
module sram_blwl_bank #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int PULSE_CYC = 2,
    parameter int MODE      = 0,
    parameter int AW        = $clog2(ROWS)
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [AW-1:0]        req_addr,
    input  logic [COLS-1:0]      req_data,
    output logic [COLS-1:0]      bl,
    output logic [ROWS-1:0]      wl,
    output logic                 done,
    output logic                 rd_valid,
    output logic [COLS-1:0]      rd_data,
    output logic                 err,
    output logic [ROWS*COLS-1:0] cfg_out,
    output logic [ROWS*COLS-1:0] cfg_outb
);

    localparam int               CW       = $clog2(PULSE_CYC + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(PULSE_CYC - 1);
    localparam logic [ROWS-1:0]  WL_ONE   = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_RD,
        S_ERR
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   erase;
    logic [AW-1:0]          addr_q;
    logic [COLS-1:0]        data_q;
    logic [ROWS*COLS-1:0]   cells;
    logic                   accept;
    logic                   in_range;

    assign accept   = req_valid && req_ready;
    assign in_range = int'(req_addr) < ROWS;
    assign cfg_out  = cells;
    assign cfg_outb = ~cells;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            bl        <= '0;
            wl        <= '0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            erase     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            // NOTE: the cell array is cleared by reset as well, so a write aborted
            // mid-pulse can never leave a partially programmed row behind.
            cells     <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        data_q    <= req_data;
                        if (!in_range) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else if (req_op) begin
                            state    <= S_RD;
                            rd_valid <= 1'b1;
                            rd_data  <= cells[int'(req_addr)*COLS +: COLS];
                        end else begin
                            // RRAM cells must be erased to zero before the set phase.
                            state <= S_SETUP;
                            cnt   <= CNT_LOAD;
                            erase <= (MODE == 1);
                            bl    <= (MODE == 1) ? '0 : req_data;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_PULSE;
                    wl    <= WL_ONE << addr_q;
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        state                           <= S_HOLD;
                        wl                              <= '0;
                        cells[int'(addr_q)*COLS +: COLS] <= bl;
                        done                            <= !erase;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (erase) begin
                        state <= S_SETUP;
                        erase <= 1'b0;
                        cnt   <= CNT_LOAD;
                        bl    <= data_q;
                    end else begin
                        state     <= S_IDLE;
                        bl        <= '0;
                        req_ready <= 1'b1;
                    end
                end
                S_RD, S_ERR: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    bl    <= '0;
                    wl    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_blwl_bank.sv
// Self-checking bench: three banks (SRAM 8 rows, RRAM 8 rows, SRAM 6 rows) compared
// cycle by cycle against a phase-arithmetic reference model.
module tb_sram_blwl_bank;

    localparam int P = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid0, valid1, valid2;
    logic        ready0, ready1, ready2;
    logic        op;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [7:0]  bl0, wl0, rdd0, bl1, wl1, rdd1, bl2, rdd2;
    logic [5:0]  wl2;
    logic        done0, rdv0, err0, done1, rdv1, err1, done2, rdv2, err2;
    logic [63:0] cfg0, cfgb0, cfg1, cfgb1;
    logic [47:0] cfg2, cfgb2;

    sram_blwl_bank #(.ROWS(8), .COLS(8), .PULSE_CYC(P), .MODE(0)) u_sram8 (
        .prog_clk(clk), .prog_rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
        .req_op(op), .req_addr(addr), .req_data(data), .bl(bl0), .wl(wl0),
        .done(done0), .rd_valid(rdv0), .rd_data(rdd0), .err(err0),
        .cfg_out(cfg0), .cfg_outb(cfgb0));

    sram_blwl_bank #(.ROWS(8), .COLS(8), .PULSE_CYC(P), .MODE(1)) u_rram8 (
        .prog_clk(clk), .prog_rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
        .req_op(op), .req_addr(addr), .req_data(data), .bl(bl1), .wl(wl1),
        .done(done1), .rd_valid(rdv1), .rd_data(rdd1), .err(err1),
        .cfg_out(cfg1), .cfg_outb(cfgb1));

    sram_blwl_bank #(.ROWS(6), .COLS(8), .PULSE_CYC(P), .MODE(0)) u_sram6 (
        .prog_clk(clk), .prog_rst_n(rst_n), .req_valid(valid2), .req_ready(ready2),
        .req_op(op), .req_addr(addr), .req_data(data), .bl(bl2), .wl(wl2),
        .done(done2), .rd_valid(rdv2), .rd_data(rdd2), .err(err2),
        .cfg_out(cfg2), .cfg_outb(cfgb2));

    typedef struct {
        logic        ready;
        logic [7:0]  bl;
        logic [7:0]  wl;
        logic        done;
        logic        rdv;
        logic        err;
        logic [7:0]  rdd;
        logic [63:0] cfg;
        logic [63:0] cfgb;
    } obs_t;

    typedef struct {
        int         k;
        bit         op;
        int         addr;
        logic [7:0] data;
        int         exp_back;
        logic [7:0] exp_rd;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem     [3][8];
    logic [7:0] last_rd [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rows_of(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic bit rram(input int k);
        return k == 1;
    endfunction

    function automatic logic [63:0] cfg_mask(input int k);
        return (k == 2) ? 64'h0000_FFFF_FFFF_FFFF : '1;
    endfunction

    function automatic logic [63:0] exp_cfg(input int k, input int a, input logic [7:0] cur,
                                            input bit use_cur);
        logic [63:0] v = '0;
        for (int r = 0; r < rows_of(k); r++)
            v[r*8 +: 8] = (use_cur && r == a) ? cur : mem[k][r];
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = '0;
            for (int r = 0; r < 8; r++) mem[k][r] = '0;
        end
    endtask

    task automatic set_valid(input int k, input logic v);
        case (k)
            0:       valid0 = v;
            1:       valid1 = v;
            default: valid2 = v;
        endcase
    endtask

    task automatic sample(input int k, output obs_t o);
        case (k)
            0: o = '{ready0, bl0, wl0, done0, rdv0, err0, rdd0, cfg0, cfgb0};
            1: o = '{ready1, bl1, wl1, done1, rdv1, err1, rdd1, cfg1, cfgb1};
            default: o = '{ready2, bl2, {2'b00, wl2}, done2, rdv2, err2, rdd2,
                           {16'h0, cfg2}, {16'h0, cfgb2}};
        endcase
    endtask

    // Issue one request to bank k at a falling edge and check every following cycle up to
    // and including the one where ready returns. With hold set, req_valid stays high and the
    // other request inputs are scrambled while busy.
    task automatic run_req(input int k, input bit rop, input int a, input logic [7:0] d,
                           input bit hold, output int back, output logic [7:0] rd1);
        obs_t       o;
        int         waited, nph, len, phase, pos;
        bit         inr;
        logic [7:0] cur, pd, e_bl, e_wl;
        logic       e_done, e_rdv, e_err, e_ready;
        logic [63:0] ecfg;
        string      tag;
        back   = -1;
        rd1    = '0;
        waited = 0;
        sample(k, o);
        while (o.ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            sample(k, o);
            waited++;
        end
        if (o.ready !== 1'b1) begin
            check($sformatf("k%0d ready wait", k), {63'h0, o.ready}, 64'h1);
            return;
        end
        op   = rop;
        addr = a[2:0];
        data = d;
        set_valid(k, 1'b1);
        @(posedge clk);
        inr = a < rows_of(k);
        nph = rram(k) ? 2 : 1;
        len = (!inr || rop) ? 1 : nph * (P + 2);
        cur = mem[k][a];
        for (int i = 1; i <= len + 1; i++) begin
            @(negedge clk);
            sample(k, o);
            if (!hold) set_valid(k, 1'b0);
            else if (i <= len) begin
                data = 8'($urandom);
                addr = 3'($urandom);
            end
            e_bl = '0; e_wl = '0; e_done = 1'b0; e_rdv = 1'b0; e_err = 1'b0;
            e_ready = (i == len + 1);
            if (i <= len) begin
                if (!inr) e_err = 1'b1;
                else if (rop) begin
                    e_rdv      = 1'b1;
                    last_rd[k] = mem[k][a];
                    rd1        = o.rdd;
                end else begin
                    phase = (i - 1) / (P + 2);
                    pos   = (i - 1) % (P + 2);
                    pd    = (rram(k) && phase == 0) ? 8'h00 : d;
                    e_bl  = pd;
                    if (pos >= 1 && pos <= P) e_wl = 8'(1 << a);
                    if (pos == P + 1) begin
                        cur    = pd;
                        e_done = (phase == nph - 1);
                    end
                end
            end
            if (o.ready === 1'b1 && back < 0) back = i;
            ecfg = exp_cfg(k, a, cur, inr && !rop);
            tag  = $sformatf("k%0d a%0d op%0d cyc%0d ", k, a, rop, i);
            check({tag, "ready"},    {63'h0, o.ready}, {63'h0, e_ready});
            check({tag, "bl"},       {56'h0, o.bl},    {56'h0, e_bl});
            check({tag, "wl"},       {56'h0, o.wl},    {56'h0, e_wl});
            check({tag, "done"},     {63'h0, o.done},  {63'h0, e_done});
            check({tag, "rd_valid"}, {63'h0, o.rdv},   {63'h0, e_rdv});
            check({tag, "rd_data"},  {56'h0, o.rdd},   {56'h0, last_rd[k]});
            check({tag, "err"},      {63'h0, o.err},   {63'h0, e_err});
            check({tag, "cfg_out"},  o.cfg,            ecfg);
            check({tag, "cfg_outb"}, o.cfgb,           ~ecfg & cfg_mask(k));
        end
        if (inr && !rop) mem[k][a] = d;
    endtask

    vec_t       vecs [12];
    int         back;
    logic [7:0] rd1;

    initial begin
        vecs[0]  = '{0, 1'b0, 3, 8'hA5, 5, 8'h00};
        vecs[1]  = '{0, 1'b1, 3, 8'h00, 2, 8'hA5};
        vecs[2]  = '{1, 1'b0, 5, 8'hFF, 9, 8'h00};
        vecs[3]  = '{1, 1'b0, 5, 8'h0F, 9, 8'h00};
        vecs[4]  = '{1, 1'b1, 5, 8'h00, 2, 8'h0F};
        vecs[5]  = '{2, 1'b0, 7, 8'h3C, 2, 8'h00};
        vecs[6]  = '{2, 1'b1, 6, 8'h00, 2, 8'h00};
        vecs[7]  = '{2, 1'b0, 5, 8'hC3, 4 + 1, 8'h00};
        vecs[8]  = '{2, 1'b1, 5, 8'h00, 2, 8'hC3};
        vecs[9]  = '{0, 1'b0, 3, 8'h5A, 5, 8'h00};
        vecs[10] = '{0, 1'b0, 3, 8'h5A, 5, 8'h00};
        vecs[11] = '{0, 1'b1, 3, 8'h00, 2, 8'h5A};

        rst_n = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        op = 1'b0; addr = '0; data = '0;
        clear_model();

        // Reset state, checked while the clock keeps running.
        #12;
        check("rst ready",    {61'h0, ready2, ready1, ready0}, 64'h0);
        check("rst bl0",      {56'h0, bl0}, 64'h0);
        check("rst wl0",      {56'h0, wl0}, 64'h0);
        check("rst flags0",   {61'h0, done0, rdv0, err0}, 64'h0);
        check("rst rd_data0", {56'h0, rdd0}, 64'h0);
        check("rst cfg0",     cfg0, 64'h0);
        check("rst cfgb0",    cfgb0, '1);
        check("rst cfg1",     cfg1, 64'h0);
        check("rst cfgb2",    {16'h0, cfgb2}, 64'h0000_FFFF_FFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready before first edge", {63'h0, ready0}, 64'h0);
        @(posedge clk);
        #1;
        check("ready after first edge", {61'h0, ready2, ready1, ready0}, 64'h7);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_req(vecs[i].k, vecs[i].op, vecs[i].addr, vecs[i].data, 1'b0, back, rd1);
            check($sformatf("vec%0d ready return", i), 64'(back), 64'(vecs[i].exp_back));
            if (vecs[i].op && vecs[i].addr < rows_of(vecs[i].k))
                check($sformatf("vec%0d rd_data", i), {56'h0, rd1}, {56'h0, vecs[i].exp_rd});
        end

        for (int n = 0; n < 60; n++)
            run_req(int'($urandom_range(0, 2)), 1'($urandom), int'($urandom_range(0, 7)),
                    8'($urandom), 1'b0, back, rd1);

        // Reset during the second PULSE cycle of a write.
        op = 1'b0; addr = 3'd2; data = 8'h3C; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk); valid0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid pulse wl", {56'h0, wl0}, 64'h04);
        check("mid pulse cfg nonzero", {63'h0, cfg0 != 64'h0}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("abort wl",    {56'h0, wl0}, 64'h0);
        check("abort bl",    {56'h0, bl0}, 64'h0);
        check("abort cfg0",  cfg0, 64'h0);
        check("abort cfgb0", cfgb0, '1);
        check("abort cfg1",  cfg1, 64'h0);
        check("abort ready", {63'h0, ready0}, 64'h0);
        clear_model();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release ready low", {63'h0, ready0}, 64'h0);
        @(posedge clk);
        #1;
        check("release ready high", {61'h0, ready2, ready1, ready0}, 64'h7);
        @(negedge clk);

        // Back-to-back writes with req_valid held and request inputs scrambled while busy.
        for (int r = 0; r < 8; r++) begin
            run_req(0, 1'b0, r, 8'($urandom), 1'b1, back, rd1);
            check($sformatf("b2b row%0d ready return", r), 64'(back), 64'(P + 3));
        end
        valid0 = 1'b0;
        for (int r = 0; r < 8; r++)
            run_req(0, 1'b1, r, 8'h00, 1'b0, back, rd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
